// File: rtl/mem_bus_arbiter_if.sv
// ---------------------------------------------------------------------------
// mem_bus_arbiter_if
// Bundles every bus signal around the memory arbiter: the two cache-miss
// master ports (m0 = instruction cache, m1 = data cache), the shared memory
// port and the one-hot grant indicator.
//
// Modports:
//   master : the arbiter's view. It receives the master requests and the
//            memory response, and drives rdata/ack back to the masters, the
//            memory strobes and grant.
//   slave  : the surrounding system's view (caches + memory), the mirror of
//            master.
// Parameters:
//   WORD_SIZE : data word width in bits
//   ADDR_BITS : address width
// ---------------------------------------------------------------------------
interface mem_bus_arbiter_if #(
  parameter int WORD_SIZE = 32,
  parameter int ADDR_BITS = 32
);
  logic [ADDR_BITS-1:0] m0_addr;
  logic [WORD_SIZE-1:0] m0_wdata;
  logic                 m0_wr;
  logic                 m0_re;
  logic [WORD_SIZE-1:0] m0_rdata;
  logic                 m0_ack;

  logic [ADDR_BITS-1:0] m1_addr;
  logic [WORD_SIZE-1:0] m1_wdata;
  logic                 m1_wr;
  logic                 m1_re;
  logic [WORD_SIZE-1:0] m1_rdata;
  logic                 m1_ack;

  logic [ADDR_BITS-1:0] mem_addr;
  logic [WORD_SIZE-1:0] mem_wdata;
  logic                 mem_wr;
  logic                 mem_re;
  logic [WORD_SIZE-1:0] mem_rdata;
  logic                 mem_ack;

  logic [1:0]           grant;

  modport master (
    input  m0_addr, m0_wdata, m0_wr, m0_re,
    input  m1_addr, m1_wdata, m1_wr, m1_re,
    input  mem_rdata, mem_ack,
    output m0_rdata, m0_ack, m1_rdata, m1_ack,
    output mem_addr, mem_wdata, mem_wr, mem_re,
    output grant
  );

  modport slave (
    output m0_addr, m0_wdata, m0_wr, m0_re,
    output m1_addr, m1_wdata, m1_wr, m1_re,
    output mem_rdata, mem_ack,
    input  m0_rdata, m0_ack, m1_rdata, m1_ack,
    input  mem_addr, mem_wdata, mem_wr, mem_re,
    input  grant
  );
endinterface

// File: rtl/mem_bus_arbiter.sv
// ---------------------------------------------------------------------------
// mem_bus_arbiter
// Shares one external memory port between the instruction cache (m0) and
// the data cache (m1). A master keeps the bus for a whole transaction
// (READ_BURST acks for a line fill, WRITE_BURST acks for a write-through),
// so the two masters' traffic is never interleaved. At least one IDLE cycle
// separates any two grants.
//
// Ports:
//   clk    : clock, all state changes on posedge
//   rst    : synchronous, active-low reset
//   io_bus : mem_bus_arbiter_if.master carrying both master ports, the
//            memory port and the one-hot grant (01 = m0, 10 = m1, 00 = idle)
//
// Configuration macro:
//   ARB_ROUND_ROBIN_EN : when defined, a simultaneous request in IDLE goes to
//                        the master that did not own the bus last. When
//                        undefined, m1 always wins over m0.
// ---------------------------------------------------------------------------
module mem_bus_arbiter #(
  parameter int WORD_SIZE   = 32,
  parameter int ADDR_BITS   = 32,
  parameter int READ_BURST  = 16,
  parameter int WRITE_BURST = 1,
  parameter int CNT_BITS    = 5
) (
  input  logic              clk,
  input  logic              rst,
  mem_bus_arbiter_if.master io_bus
);

  localparam logic [CNT_BITS-1:0] ReadLimit  = CNT_BITS'(READ_BURST);
  localparam logic [CNT_BITS-1:0] WriteLimit = CNT_BITS'(WRITE_BURST);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } state_t;

  state_t              r_state;
  logic [1:0]          r_grant;
  logic [CNT_BITS-1:0] r_count;
  logic [CNT_BITS-1:0] r_limit;

  logic                 w_m0Req;
  logic                 w_m1Req;
  logic                 w_pickM1;
  logic                 w_ownerReq;
  logic                 w_lastAck;
  logic [ADDR_BITS-1:0] w_memAddr;
  logic [WORD_SIZE-1:0] w_memWdata;
  logic                 w_memWr;
  logic                 w_memRe;
  logic                 w_m0Ack;
  logic                 w_m1Ack;

  assign w_m0Req = io_bus.m0_wr | io_bus.m0_re;
  assign w_m1Req = io_bus.m1_wr | io_bus.m1_re;

`ifdef ARB_ROUND_ROBIN_EN
  // Remembers who was granted last so a contested IDLE goes to the other one.
  logic r_lastOwnerM1;

  assign w_pickM1 = w_m1Req & (~w_m0Req | ~r_lastOwnerM1);
`else
  assign w_pickM1 = w_m1Req;
`endif

  // The owner keeps the bus only while it still holds wr or re.
  assign w_ownerReq = (r_state == OWN1) ? w_m1Req : w_m0Req;

  // Final ack of the transaction; count never passes limit-1.
  assign w_lastAck = io_bus.mem_ack && (r_count == (r_limit - CNT_BITS'(1)));

  // Arbitration state machine. Grant, burst limit and word count are all
  // registered here; every exit from OWNx clears the count and lands in IDLE,
  // which guarantees the idle cycle between back-to-back grants.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= IDLE;
      r_grant <= 2'b00;
      r_count <= '0;
      r_limit <= ReadLimit;
`ifdef ARB_ROUND_ROBIN_EN
      r_lastOwnerM1 <= 1'b0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          r_count <= '0;
          if (w_pickM1) begin
            r_state <= OWN1;
            r_grant <= 2'b10;
            r_limit <= io_bus.m1_wr ? WriteLimit : ReadLimit;
`ifdef ARB_ROUND_ROBIN_EN
            r_lastOwnerM1 <= 1'b1;
`endif
          end else if (w_m0Req) begin
            r_state <= OWN0;
            r_grant <= 2'b01;
            r_limit <= io_bus.m0_wr ? WriteLimit : ReadLimit;
`ifdef ARB_ROUND_ROBIN_EN
            r_lastOwnerM1 <= 1'b0;
`endif
          end
        end
        OWN0, OWN1: begin
          // An ack in the abort cycle is still forwarded combinationally.
          if (!w_ownerReq || w_lastAck) begin
            r_state <= IDLE;
            r_grant <= 2'b00;
            r_count <= '0;
          end else if (io_bus.mem_ack) begin
            r_count <= r_count + CNT_BITS'(1);
          end
        end
        default: begin
          r_state <= IDLE;
          r_grant <= 2'b00;
          r_count <= '0;
        end
      endcase
    end
  end

  // Bus routing: the owner's request side drives memory and memory's ack goes
  // only to the owner. A master raising wr and re together is treated as a
  // write, so its re is masked off the memory port.
  always_comb begin
    w_memAddr  = '0;
    w_memWdata = '0;
    w_memWr    = 1'b0;
    w_memRe    = 1'b0;
    w_m0Ack    = 1'b0;
    w_m1Ack    = 1'b0;
    case (r_state)
      OWN0: begin
        w_memAddr  = io_bus.m0_addr;
        w_memWdata = io_bus.m0_wdata;
        w_memWr    = io_bus.m0_wr;
        w_memRe    = io_bus.m0_re & ~io_bus.m0_wr;
        w_m0Ack    = io_bus.mem_ack;
      end
      OWN1: begin
        w_memAddr  = io_bus.m1_addr;
        w_memWdata = io_bus.m1_wdata;
        w_memWr    = io_bus.m1_wr;
        w_memRe    = io_bus.m1_re & ~io_bus.m1_wr;
        w_m1Ack    = io_bus.mem_ack;
      end
      default: begin
        w_memAddr  = '0;
      end
    endcase
  end

  assign io_bus.mem_addr  = w_memAddr;
  assign io_bus.mem_wdata = w_memWdata;
  assign io_bus.mem_wr    = w_memWr;
  assign io_bus.mem_re    = w_memRe;
  assign io_bus.m0_ack    = w_m0Ack;
  assign io_bus.m1_ack    = w_m1Ack;
  // Read data is only meaningful alongside an ack, so both masters see it.
  assign io_bus.m0_rdata  = io_bus.mem_rdata;
  assign io_bus.m1_rdata  = io_bus.mem_rdata;
  assign io_bus.grant     = r_grant;

endmodule
